mmul3: RTL

- Multi-cycle integer matrix multiplier computing C = A × B, where A is M×N, B is N×P and C is M×P.
- Successor to the single-MAC multiplier: adds reset, a start/ready/done handshake and operand capture.
- Also adds LANES parallel MAC lanes, signed/unsigned mode and a widened accumulator.
- Sits between operand staging registers and the result consumer in the compute datapath.

---
 rtl/mmul3_pkg.sv | 28 ++
 rtl/mmul3_mac.sv | 57 +++++
 rtl/mmul3.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mmul3_pkg.sv
// Shared types and helpers for the mmul3 matrix multiplier: FSM state encoding,
// counter-width sizing and row-major element offsets for the A, B and C buses.
package mmul3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int a_off(input int r, input int c, input int n_cols, input int w);
        return w * (r * n_cols + c);
    endfunction

    function automatic int b_off(input int r, input int c, input int p_cols, input int w);
        return w * (r * p_cols + c);
    endfunction

    function automatic int c_off(input int r, input int c, input int p_cols, input int accw);
        return accw * (r * p_cols + c);
    endfunction

endpackage

// File: rtl/mmul3_mac.sv
// One multiply-accumulate lane: extends both operands to the accumulator width,
// multiplies modulo 2^ACCW and accumulates, restarting after each writeback.
module mmul3_mac
    import mmul3_pkg::*;
#(
    parameter int W      = 16,
    parameter int ACCW   = 34,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            wb_i,
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    output logic [ACCW-1:0] sum_o
);

    logic [ACCW-1:0] a_ext;
    logic [ACCW-1:0] b_ext;
    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] acc_q;
    logic [ACCW-1:0] acc_d;

    generate
        if (SIGNED != 0) begin : g_sext
            assign a_ext = {{(ACCW-W){a_i[W-1]}}, a_i};
            assign b_ext = {{(ACCW-W){b_i[W-1]}}, b_i};
        end else begin : g_zext
            assign a_ext = {{(ACCW-W){1'b0}}, a_i};
            assign b_ext = {{(ACCW-W){1'b0}}, b_i};
        end
    endgenerate

    // Low ACCW bits of the product are the same for signed and unsigned operands.
    assign prod  = a_ext * b_ext;
    assign sum_o = acc_q + prod;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = wb_i ? '0 : sum_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mmul3.sv
// Multi-cycle C = A x B matrix multiplier with LANES parallel MAC lanes,
// a start/ready/done handshake and latched operands.
module mmul3
    import mmul3_pkg::*;
#(
    parameter int M      = 2,
    parameter int N      = 2,
    parameter int P      = 2,
    parameter int W      = 16,
    parameter int ACCW   = 2*W + $clog2(N+1),
    parameter int LANES  = 1,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [M*N*W-1:0]      A,
    input  logic [N*P*W-1:0]      B,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [M*P*ACCW-1:0]   C
);

    localparam int JB = (LANES >= 1) ? P / LANES : 1;
    localparam int IW = cnt_w(M);
    localparam int JW = cnt_w(JB);
    localparam int KW = cnt_w(N);

    localparam logic [IW-1:0] I_LAST  = IW'(M - 1);
    localparam logic [JW-1:0] JB_LAST = JW'(JB - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);

    generate
        if (M < 1 || N < 1 || P < 1 || LANES < 1) begin : g_bad_dims
            $fatal(1, "mmul3: M, N, P and LANES must all be at least 1");
        end
        if (LANES >= 1 && (P % LANES) != 0) begin : g_bad_lanes
            $fatal(1, "mmul3: P must be a multiple of LANES");
        end
        if (ACCW < 2*W) begin : g_bad_accw
            $fatal(1, "mmul3: ACCW must be at least 2*W");
        end
    endgenerate

    state_e            state_q;
    state_e            state_d;
    logic [M*N*W-1:0]  a_q;
    logic [N*P*W-1:0]  b_q;
    logic [IW-1:0]     i_q;
    logic [JW-1:0]     jb_q;
    logic [KW-1:0]     k_q;
    logic [ACCW-1:0]   c_q [M][JB][LANES];

    logic              accept;
    logic              running;
    logic              last_i;
    logic              last_jb;
    logic              last_k;

    logic [W-1:0]      a_arr [M][N];
    logic [W-1:0]      b_arr [N][JB][LANES];
    logic [W-1:0]      a_sel;
    logic [W-1:0]      b_sel [LANES];
    logic [ACCW-1:0]   lane_sum [LANES];

    assign accept  = (state_q == IDLE) && start;
    assign running = (state_q == RUN);
    assign last_i  = (i_q == I_LAST);
    assign last_jb = (jb_q == JB_LAST);
    assign last_k  = (k_q == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_i && last_jb && last_k) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
    end

    // Counters nest k (inner), jb, i (outer); they are only meaningful in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            i_q  <= '0;
            jb_q <= '0;
            k_q  <= '0;
        end else if (accept) begin
            a_q  <= A;
            b_q  <= B;
            i_q  <= '0;
            jb_q <= '0;
            k_q  <= '0;
        end else if (running) begin
            if (last_k) begin
                k_q <= '0;
                if (last_jb) begin
                    jb_q <= '0;
                    i_q  <= last_i ? '0 : i_q + 1'b1;
                end else begin
                    jb_q <= jb_q + 1'b1;
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Reshape the latched operands so lanes can index them by counter value.
    genvar gr, gc, gi;
    generate
        for (gr = 0; gr < M; gr++) begin : g_a_row
            for (gc = 0; gc < N; gc++) begin : g_a_col
                assign a_arr[gr][gc] = a_q[a_off(gr, gc, N, W) +: W];
            end
        end
        for (gr = 0; gr < N; gr++) begin : g_b_row
            for (gc = 0; gc < JB; gc++) begin : g_b_blk
                for (gi = 0; gi < LANES; gi++) begin : g_b_lane
                    assign b_arr[gr][gc][gi] = b_q[b_off(gr, gc*LANES + gi, P, W) +: W];
                end
            end
        end
        for (gr = 0; gr < M; gr++) begin : g_c_row
            for (gc = 0; gc < JB; gc++) begin : g_c_blk
                for (gi = 0; gi < LANES; gi++) begin : g_c_lane
                    assign C[c_off(gr, gc*LANES + gi, P, ACCW) +: ACCW] = c_q[gr][gc][gi];
                end
            end
        end
    endgenerate

    assign a_sel = a_arr[i_q][k_q];

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign b_sel[gi] = b_arr[k_q][jb_q][gi];

            mmul3_mac #(
                .W      (W),
                .ACCW   (ACCW),
                .SIGNED (SIGNED)
            ) u_mac (
                .clk   (clk),
                .rst_n (rst_n),
                .clr_i (accept),
                .en_i  (running),
                .wb_i  (last_k),
                .a_i   (a_sel),
                .b_i   (b_sel[gi]),
                .sum_o (lane_sum[gi])
            );
        end
    endgenerate

    // C keeps the previous job's values until each element is rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < M; r++) begin
                for (int j = 0; j < JB; j++) begin
                    for (int l = 0; l < LANES; l++) begin
                        c_q[r][j][l] <= '0;
                    end
                end
            end
        end else if (running && last_k) begin
            for (int l = 0; l < LANES; l++) begin
                c_q[i_q][jb_q][l] <= lane_sum[l];
            end
        end
    end

endmodule
